alu_multicycle: RTL

Execute-stage ALU that consumes the 3-bit ALU control code from the ALU control decoder, together with the two EX operands. Single-cycle ops (ADD/SUB/AND/OR) produce a registered result one cycle after issue. MUL runs as an iterative 32-step shift-add unit and asserts busy_o so the hazard unit stalls IF/ID/EX. The result and zero flag feed the EX/MEM pipeline register.

---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_iter.sv | 56 +++++
 rtl/alu_multicycle.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder and
// the execute-stage ALU state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per enabled edge.
// product_o is the accumulator value after the current step, so the caller
// can capture the final result on the same edge that performs the last step.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    // Next accumulator value for the step in progress.
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
    end

    assign done_o    = (r_cnt == CNT_W'(WIDTH - 1));
    assign product_o = w_acc_next;

    // Operand latch on load, shift-add step otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (load_i) begin
            r_mcand  <= a_i;
            r_mplier <= b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (step_i) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR with registered result,
// plus a WIDTH-cycle iterative MUL that stalls the front end via busy_o.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic             w_load;
    logic             w_step;
    logic             w_res_we;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_simple;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_load),
        .step_i    (w_step),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );

    // Single-cycle op datapath; unsupported codes yield zero.
    always_comb begin
        w_simple = '0;
        case (ALUCtrl_i)
            ALU_ADD: w_simple = data1_i + data2_i;
            ALU_SUB: w_simple = data1_i - data2_i;
            ALU_AND: w_simple = data1_i & data2_i;
            ALU_OR:  w_simple = data1_i | data2_i;
            default: w_simple = '0;
        endcase
    end

    // Next-state and result-write decode; flush beats issue and aborts MUL.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_res_we     = 1'b0;
        w_res        = w_simple;
        case (r_state)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        w_load       = 1'b1;
                        w_state_next = MUL;
                    end else begin
                        w_res_we = 1'b1;
                    end
                end
            end
            MUL: begin
                if (flush_i) begin
                    w_state_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_mul_done) begin
                        w_res_we     = 1'b1;
                        w_res        = w_product;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output registers; data_o/zero_o hold between results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= '0;
            zero_o  <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            valid_o <= w_res_we;
            if (w_res_we) begin
                data_o <= w_res;
                zero_o <= (w_res == '0);
            end
        end
    end

    assign busy_o = (r_state == MUL);

endmodule
